// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_ctrl_pkg;

  // Scan FSM states: display off, digit lit, inter-digit blanking gap.
  typedef enum logic [1:0] {StOff, StShow, StGap} scan_state_e;

  // Inactive level of one digit-select line; replicated to NDIG for "all digits off".
  localparam logic SEG_OFF = 1'b1;

endpackage

// File: rtl/seg_lzb_mask.sv
// Per-digit blank vector: forced-blank mask OR leading-zero blanking (digit 0 never lz-blanked).
module seg_lzb_mask
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NDIG = 8
) (
  input  logic [4*NDIG-1:0] word,
  input  logic [NDIG-1:0]   mask,
  input  logic              lzb_en,
  output logic [NDIG-1:0]   blank
);

  logic zero_above;

  // Walk from the most significant digit down, tracking "this and all higher nibbles are zero".
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above & (word[4*i +: 4] == 4'd0);
      blank[i]   = mask[i] | (lzb_en & zero_above & (i != 0));
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered display word.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NDIG = 8,
  parameter int unsigned DIV  = 50000,
  parameter int unsigned GAP  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic              lzb_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  input  logic [NDIG-1:0]   in_blank,
  output logic [NDIG-1:0]   dig_sel,
  output logic [3:0]        bcd_x,
  output logic              bcd_en,
  output logic              frame_done
);

  localparam int unsigned IW   = $clog2(NDIG);
  localparam int unsigned CMAX = (DIV > GAP) ? DIV : GAP;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  scan_state_e       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, idx_next;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] act_data_q, pend_data_q;
  logic [NDIG-1:0]   act_mask_q, pend_mask_q;
  logic              pend_q;

  logic              show_end, gap_end, slot_end;
  logic              accept, commit;
  logic [NDIG-1:0]   blank;

  seg_lzb_mask #(
    .NDIG (NDIG)
  ) u_lzb (
    .word   (act_data_q),
    .mask   (act_mask_q),
    .lzb_en (lzb_en),
    .blank  (blank)
  );

  // Slot boundaries and handshake decode.
  always_comb begin
    show_end   = (state_q == StShow) && (cnt_q == DIV_LAST);
    gap_end    = (state_q == StGap) && (cnt_q == GAP_LAST);
    slot_end   = (GAP == 0) ? show_end : gap_end;
    frame_done = slot_end && (idx_q == IDX_LAST);
    idx_next   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    in_ready   = !pend_q;
    accept     = in_valid && !pend_q;
    commit     = pend_q && (frame_done || (state_q == StOff));
  end

  // Next-state logic; scan_en low overrides every other transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        state_d = StShow;
        idx_d   = '0;
        cnt_d   = '0;
      end
      StShow: begin
        if (show_end) begin
          cnt_d = '0;
          if (GAP == 0) begin
            idx_d = idx_next;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StGap: begin
        if (gap_end) begin
          state_d = StShow;
          idx_d   = idx_next;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StOff;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (!scan_en) begin
      state_d = StOff;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // FSM state, digit index and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending/active double buffer; accept and commit are mutually exclusive via pend_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
      act_data_q  <= '0;
      act_mask_q  <= '0;
    end else if (accept) begin
      pend_q      <= 1'b1;
      pend_data_q <= in_data;
      pend_mask_q <= in_blank;
    end else if (commit) begin
      pend_q     <= 1'b0;
      act_data_q <= pend_data_q;
      act_mask_q <= pend_mask_q;
    end
  end

  // Display outputs, decoded from registers only.
  always_comb begin
    dig_sel = {NDIG{SEG_OFF}};
    bcd_x   = 4'd0;
    bcd_en  = 1'b0;
    if (state_q == StShow) begin
      dig_sel[idx_q] = ~SEG_OFF;
      bcd_x          = act_data_q[4*idx_q +: 4];
      bcd_en         = !blank[idx_q];
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an NDIG-digit seven-segment display that shares one BCD-to-segment decoder across all digits. Accepts a packed BCD display word through a valid/ready handshake and double-buffers it so updates land only on frame boundaries, which prevents tearing. Steps through the digits with a programmable dwell and a ghosting-suppression gap. Drives the active-low one-hot digit select plus the shared decoder's nibble and enable, with optional leading-zero blanking.

## Interface
- NDIG, 8, number of digits (≥2)
- DIV, 50000, clk cycles each digit is lit (≥1)
- GAP, 16, clk cycles all digits are off between digits (≥0; 0 skips the gap)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- scan_en  in  1  1 = scanning, 0 = display off
- lzb_en  in  1  leading-zero blanking enable
- in_valid  in  1  display word offered
- in_ready  out  1  pending buffer free
- in_data  in  4*NDIG  BCD word; nibble i = digit i (0 = least significant)
- in_blank  in  NDIG  per-digit force-blank mask, captured with in_data
- dig_sel  out  NDIG  digit select, active-low one-hot
- bcd_x  out  4  nibble to shared decoder
- bcd_en  out  1  decoder enable (0 = segments off)
- frame_done  out  1  one-cycle pulse at frame wrap

## Operation
- Registers:
  - active word/mask
  - pending word/mask plus pend flag
  - state ∈ {OFF, SHOW, GAP}
  - idx (clog2 NDIG bits)
  - cnt (dwell counter, wide enough for max(DIV,GAP))
- Handshake:
  - in_ready = !pend.
  - Accept on in_valid && in_ready: write pending, set pend.
  - in_data and in_blank are sampled only on accept.
- Commit (pending→active, clear pend) happens when:
  - frame wrap occurs with pend = 1, or
  - state = OFF with pend = 1.
  - Commit and accept never occur in the same cycle, because in_ready = 0 while pend = 1.
- FSM:
  - OFF: if scan_en, go to SHOW with idx = 0, cnt = 0.
  - SHOW: cnt counts 0..DIV-1. At DIV-1, go to GAP with cnt = 0, or if GAP = 0 advance directly as described under GAP's exit.
  - GAP: cnt counts 0..GAP-1. At the end, idx increments and the FSM returns to SHOW.
  - If idx was NDIG-1, idx wraps to 0 and this is the frame wrap.
  - From any state, scan_en = 0 forces OFF next cycle with idx = 0 and cnt = 0. This overrides all other transitions.
- Outputs are combinational from registers only; there is no input-to-output path.
  - SHOW: dig_sel bit idx = 0, all other bits = 1. bcd_x = active nibble idx. bcd_en = !blank(idx).
  - OFF and GAP: dig_sel all 1s, bcd_en = 0, bcd_x = 0.
  - frame_done = 1 in the last cycle of the last digit slot (GAP end, or SHOW end if GAP = 0) with idx = NDIG-1.
- blank(i) is true if active mask bit i is set, or if all of the following hold:
  - lzb_en = 1
  - i ≠ 0
  - active nibbles NDIG-1..i are all 0
- Nibbles >9 pass through unchanged; the decoder shows them as all-off.

## Timing
- Reset values: state OFF, idx 0, cnt 0, active/pending 0, pend 0, in_ready 1, dig_sel all 1s, bcd_x 0, bcd_en 0, frame_done 0.
- Frame period: NDIG·(DIV+GAP) cycles.
- Accept-to-display latency:
  - With scan_en = 0: 1 cycle.
  - With scan_en = 1: until the next frame wrap, at most one frame + 1 cycle.
  - The committed word is visible from the first SHOW cycle of digit 0.
- Pending was set in the cycle before wrap: commit occurs at wrap. in_ready rises in the cycle after frame_done.
- scan_en deasserted mid-digit: dig_sel goes all 1s next cycle. Any pending word commits in that OFF cycle.
- Asynchronous reset mid-frame: immediate return to reset values. Pending data is discarded.

## Structure
- Shared package holds:
  - state enum {OFF, SHOW, GAP}
  - the SEG_OFF digit-select constant (all 1s)
- Natural sub-module: seg_lzb_mask. It is combinational and computes the NDIG blank vector from the active word, mask and lzb_en.
- The top holds the FSM, counters and buffers.
- The shared decoder is instantiated outside this block and driven by bcd_x/bcd_en.

## Test plan
Bench parameters: NDIG=4, DIV=4, GAP=1.
1. Reset: release rst_n. Expect dig_sel = 1111, bcd_en = 0, in_ready = 1, frame_done = 0, with no activity while scan_en = 0.
2. Load and scan: load 0x1234 with scan_en = 0, then assert scan_en. Expect the following sequence:
   - dig_sel = 1110, bcd_x = 4, bcd_en = 1 for 4 cycles.
   - Then dig_sel = 1111 for 1 cycle.
   - Then 1101/3, 1011/2, 0111/1 in turn.
   - frame_done pulses at cycle 20, and the frame repeats.
3. Leading-zero blanking, with lzb_en = 1:
   - 0x0040: digits 3 and 2 have bcd_en = 0; digit 1 shows 4; digit 0 shows 0 with bcd_en = 1.
   - 0x0000: only digit 0 is enabled.
   - in_blank = 0001 on 0x0040: digit 0 has bcd_en = 0.
4. Double-buffering: while scanning 0x1234, accept 0x5678 mid-frame, then offer 0x9999.
   - in_ready = 0 until after frame_done; 0x9999 is not accepted.
   - The next frame shows 5,6,7,8, starting with digit 0 = 8.
   - 0x9999 is accepted the cycle after frame_done.
5. scan_en = 0 during the SHOW of digit 2 with a word pending: next cycle dig_sel = 1111 and the pending word commits. Re-enable: scanning restarts at digit 0.
6. Assert rst_n low asynchronously mid-GAP: outputs reach reset values without waiting for a clk edge.
